e_mdu: RTL and testbench

- Execute-stage multiply/divide unit of the 5-stage pipeline.
- Consumes the forwarded E-stage operands (E_RD1_FW, E_RD2_FW) and holds the HI/LO registers.
- Models multi-cycle latency with a busy counter, which the hazard unit uses to stall D-stage multiply/divide instructions.
- Supplies mfhi/mflo read data to the E-stage result mux.

---
 rtl/e_mdu.sv | 147 ++++++++++++++
 tb/tb_e_mdu.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit.
// Owns the architectural HI/LO registers. A mult/div result is computed in the
// issue cycle, parked in temporary registers, and committed to HI/LO when the
// busy counter expires, so the pipeline sees the multi-cycle latency.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDUop,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        req,
  output logic        E_Start,
  output logic        E_Busy,
  output logic [31:0] E_MDU_Out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int          CW         = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   temp_hi;
  logic [31:0]   temp_lo;
  logic          temp_commit;   // cleared for divide-by-zero: HI/LO stay untouched

  logic          accept;
  logic [CW-1:0] load_cnt;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic          res_commit;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] divisor;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;
  logic               div_zero;
  logic               div_ovf;

  // Decode of the start strobe and the mfhi/mflo read port; no state involved.
  always_comb begin
    E_Start   = (E_MDUop == OP_MULT) || (E_MDUop == OP_MULTU) ||
                (E_MDUop == OP_DIV)  || (E_MDUop == OP_DIVU);
    E_MDU_Out = 32'd0;
    if (E_MDUop == OP_MFHI) E_MDU_Out = HI;
    else if (E_MDUop == OP_MFLO) E_MDU_Out = LO;
  end

  assign accept = E_Start && !req && !E_Busy;

  // Full-width arithmetic on the forwarded operands. Division by zero and the
  // signed 0x80000000 / -1 case both divide by 1 instead: the overflow case
  // then yields exactly quotient 0x80000000, remainder 0, and divide-by-zero
  // never reaches a real divider with a zero divisor.
  always_comb begin
    prod_s   = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
    prod_u   = {32'd0, E_A} * {32'd0, E_B};
    div_zero = (E_B == 32'd0);
    div_ovf  = (E_A == 32'h8000_0000) && (E_B == 32'hFFFF_FFFF);
    divisor  = (div_zero || div_ovf) ? 32'd1 : E_B;
    quo_s    = $signed(E_A) / $signed(divisor);
    rem_s    = $signed(E_A) % $signed(divisor);
    quo_u    = E_A / divisor;
    rem_u    = E_A % divisor;
  end

  // Select the result and latency of the operation being issued.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case below can leave a value held and infer a latch.
    res_hi     = 32'd0;
    res_lo     = 32'd0;
    res_commit = 1'b1;
    load_cnt   = CW'(MULT_CYCLES);
    case (E_MDUop)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_hi     = rem_s;
        res_lo     = quo_s;
        res_commit = !div_zero;
        load_cnt   = CW'(DIV_CYCLES);
      end
      OP_DIVU: begin
        res_hi     = rem_u;
        res_lo     = quo_u;
        res_commit = !div_zero;
        load_cnt   = CW'(DIV_CYCLES);
      end
      default: ;
    endcase
  end

  // Busy counter, temporary result latch, HI/LO commit and mthi/mtlo writes.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the temporary result registers are reset along with HI/LO so an
    // operation interrupted by reset can never commit stale data afterwards.
    if (reset) begin
      cnt         <= '0;
      E_Busy      <= 1'b0;
      temp_hi     <= 32'd0;
      temp_lo     <= 32'd0;
      temp_commit <= 1'b0;
      HI          <= 32'd0;
      LO          <= 32'd0;
    end else if (E_Busy) begin
      // NOTE: non-blocking assignments make every register here update from
      // the pre-edge values, so the cnt test below sees the old count.
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        E_Busy <= 1'b0;
        if (temp_commit) begin
          HI <= temp_hi;
          LO <= temp_lo;
        end
      end
    end else if (accept) begin
      temp_hi     <= res_hi;
      temp_lo     <= res_lo;
      temp_commit <= res_commit;
      cnt         <= load_cnt;
      E_Busy      <= 1'b1;
    end else if (!req) begin
      if (E_MDUop == OP_MTHI) HI <= E_A;
      else if (E_MDUop == OP_MTLO) LO <= E_A;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed tests for e_mdu with hand-computed expected values.
module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        start;
  logic        busy;
  logic [31:0] mdu_out;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .E_MDUop   (op),
    .E_A       (a),
    .E_B       (b),
    .req       (req),
    .E_Start   (start),
    .E_Busy    (busy),
    .E_MDU_Out (mdu_out),
    .HI        (hi),
    .LO        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance one edge; inputs and outputs are touched 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op for exactly one edge, then return to none.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y;
    step();
    op = 4'd0; a = 32'd0; b = 32'd0;
  endtask

  // Called right after an accepting edge; counts cycles with busy high (bounded).
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 50) begin
      cycles++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; op = 4'd0; a = 32'd0; b = 32'd0; req = 1'b0;
    step(); step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
    reset = 1'b0;
    step();
    op = 4'd15; #1;
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL start_op15: got %b want 0", start); end
    n_checks++; if (mdu_out !== 32'd0) begin n_fail++; $display("FAIL out_op15: got %h want 0", mdu_out); end
    op = 4'd4; #1;
    n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL start_op4: got %b want 1", start); end
    op = 4'd5; #1;
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL start_op5: got %b want 0", start); end
    op = 4'd0;
  endtask

  task automatic test_mult();
    int cyc;
    op = 4'd1; a = 32'hFFFF_FFFD; b = 32'd7; #1;
    n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL mult_start: got %b want 1", start); end
    step();
    op = 4'd0; a = 32'd0; b = 32'd0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy_rise: got %b want 1", busy); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL mult_lo_early: got %h want 0", lo); end
    wait_idle(cyc);
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want 5", cyc); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
    op = 4'd5; #1;
    n_checks++; if (mdu_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mfhi: got %h want ffffffff", mdu_out); end
    op = 4'd6; #1;
    n_checks++; if (mdu_out !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mflo: got %h want ffffffeb", mdu_out); end
    op = 4'd0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle(cyc);
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d want 5", cyc); end
    n_checks++; if (hi !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_hi: got %h want 00000001", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
    issue(4'd4, 32'd7, 32'd2);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b want 1", busy); end
    wait_idle(cyc);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL divu_busy_cycles: got %0d want 10", cyc); end
    n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL divu_lo: got %h want 00000003", lo); end
    n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL divu_hi: got %h want 00000001", hi); end
  endtask

  task automatic test_div();
    int cyc;
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(cyc);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL div_busy_cycles: got %0d want 10", cyc); end
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    issue(4'd3, 32'd1234, 32'd0);
    wait_idle(cyc);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL div0_busy_cycles: got %0d want 10", cyc); end
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div0_lo: got %h want fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_hi: got %h want ffffffff", hi); end
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(cyc);
    n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL divovf_lo: got %h want 80000000", lo); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL divovf_hi: got %h want 00000000", hi); end
  endtask

  task automatic test_mthi_mtlo();
    int cyc;
    issue(4'd7, 32'h1234_5678, 32'd0);
    n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi: got %h want 12345678", hi); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b want 0", busy); end
    issue(4'd8, 32'h9ABC_DEF0, 32'd0);
    n_checks++; if (lo !== 32'h9ABC_DEF0) begin n_fail++; $display("FAIL mtlo: got %h want 9abcdef0", lo); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy: got %b want 0", busy); end
    n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h want 12345678", hi); end
    issue(4'd1, 32'd2, 32'd3);
    issue(4'd7, 32'hDEAD_BEEF, 32'd0);
    n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_busy_ignored: got %h want 12345678", hi); end
    wait_idle(cyc);
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL mult23_hi: got %h want 00000000", hi); end
    n_checks++; if (lo !== 32'd6) begin n_fail++; $display("FAIL mult23_lo: got %h want 00000006", lo); end
  endtask

  task automatic test_req();
    int cyc;
    req = 1'b1; op = 4'd1; a = 32'd3; b = 32'd4; #1;
    n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL req_start: got %b want 1", start); end
    step();
    op = 4'd0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL req_busy: got %b want 0", busy); end
    n_checks++; if (lo !== 32'd6) begin n_fail++; $display("FAIL req_lo_kept: got %h want 00000006", lo); end
    op = 4'd8; a = 32'h5555_5555;
    step();
    op = 4'd0; req = 1'b0;
    n_checks++; if (lo !== 32'd6) begin n_fail++; $display("FAIL req_mtlo: got %h want 00000006", lo); end
    issue(4'd1, 32'd3, 32'd4);
    step();
    req = 1'b1;
    step();
    req = 1'b0;
    wait_idle(cyc);
    n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL req_inflight_rest: got %0d want 3", cyc); end
    n_checks++; if (lo !== 32'd12) begin n_fail++; $display("FAIL req_inflight_lo: got %h want 0000000c", lo); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL req_inflight_hi: got %h want 00000000", hi); end
  endtask

  task automatic test_async_reset();
    int cyc;
    issue(4'd7, 32'hAAAA_0001, 32'd0);
    issue(4'd3, 32'd100, 32'd7);
    step();
    step();
    reset = 1'b1; #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b want 0", busy); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL areset_hi: got %h want 0", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL areset_lo: got %h want 0", lo); end
    step();
    reset = 1'b0;
    repeat (12) step();
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL areset_no_commit_hi: got %h want 0", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL areset_no_commit_lo: got %h want 0", lo); end
    issue(4'd1, 32'd5, 32'd6);
    wait_idle(cyc);
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL post_reset_cycles: got %0d want 5", cyc); end
    n_checks++; if (lo !== 32'd30) begin n_fail++; $display("FAIL post_reset_lo: got %h want 0000001e", lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_div();
    test_mthi_mtlo();
    test_req();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
